// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory request sequencer.
//   ADDR_W    : memory address width (16 words)
//   DATA_W    : memory data width
//   mem_req_t : one buffered request {we, addr, wdata}
package mem_seq_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request buffer built from register storage, so the head entry
// is available combinationally in the same cycle it becomes the oldest.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (ignored when full, even with a pop)
//   push_data  : request to store
//   pop        : drop the head entry (ignored when empty)
//   full/empty : occupancy flags
//   head       : oldest stored request
module mem_req_fifo
  import mem_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  mem_req_t push_data,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output mem_req_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  mem_req_t         mem_q [DEPTH];

  // Occupancy flags, qualified push/pop and next pointer/count values.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    head     = mem_q[rd_ptr_q];
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head never carries stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/mem_req_sequencer.sv
// Upstream command stage for a 16x32 memory. Buffers read/write requests
// in order, issues at most one memory operation per cycle from the FIFO
// head, and returns read data through a single-entry response register.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   req_valid/req_ready          : request handshake
//   req_we/req_addr/req_wdata    : request payload (wdata ignored for reads)
//   rsp_valid/rsp_ready/rsp_rdata: read response handshake and data
//   mem_en/mem_re                : memory write / read enables (never both)
//   mem_addr/mem_wdata           : memory address and write data (0 when idle)
//   mem_rdata/mem_valid          : registered read data and its valid flag
//   rd_err                       : sticky flag, read returned without mem_valid
module mem_req_sequencer #(
  parameter int ADDR_W     = mem_seq_pkg::ADDR_W,
  parameter int DATA_W     = mem_seq_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              rd_err
);

  import mem_seq_pkg::*;

  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              issue_wr, issue_rd;
  mem_req_t          req_in, head;
  logic              rd_pend_q, rd_pend_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rd_err_q, rd_err_d;

  mem_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (req_in),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Request acceptance: a full buffer refuses even if the head pops now.
  always_comb begin
    req_ready    = !fifo_full;
    push         = req_valid && !fifo_full;
    req_in.we    = req_we;
    req_in.addr  = req_addr;
    req_in.wdata = req_wdata;
  end

  // Issue from the FIFO head. A read waits until the previous read has
  // returned and its response has been taken, so the single response
  // register can never be overwritten; writes are never blocked.
  always_comb begin
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    if (!fifo_empty) begin
      if (head.we) begin
        issue_wr = 1'b1;
      end else if (!rd_pend_q && !rsp_valid_q) begin
        issue_rd = 1'b1;
      end else begin
        issue_rd = 1'b0;
      end
    end else begin
      issue_wr = 1'b0;
    end
    pop       = issue_wr || issue_rd;
    mem_en    = issue_wr;
    mem_re    = issue_rd;
    mem_addr  = pop ? head.addr : '0;
    mem_wdata = issue_wr ? head.wdata : '0;
  end

  // Read return and response hold. rd_pend marks the cycle in which the
  // memory presents the data captured at the end of the issue cycle.
  always_comb begin
    rd_pend_d   = issue_rd;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (rd_pend_q) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = mem_rdata;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
    // Data is still captured when mem_valid is missing; only the flag records it.
    rd_err_d  = rd_err_q || (rd_pend_q && !mem_valid);
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
    rd_err    = rd_err_q;
  end

  // Read-tracking, response and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rd_err_q    <= 1'b0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rd_err_q    <= rd_err_d;
    end
  end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer: a directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based
// reference of the request stream and an array image of memory contents.
module tb_mem_req_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = 4'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_re;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_valid;
  logic        rd_err;

  // Environment: the 16x32 memory with registered read data.
  logic [31:0] bmem [16] = '{default: 32'd0};
  logic        mem_valid_r = 1'b0;
  logic        kill_valid = 1'b0;
  assign mem_valid = mem_valid_r & ~kill_valid;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) bmem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= bmem[mem_addr];
    mem_valid_r <= mem_re;
  end

  mem_req_sequencer #(.ADDR_W(4), .DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .rd_err(rd_err)
  );

  // Reference model state.
  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } tb_req_t;

  tb_req_t     pend_q [$];   // accepted, not yet issued
  logic [31:0] exp_q [$];    // read data owed to the consumer, in order
  logic [31:0] ref_mem [16] = '{default: 32'd0};
  bit          m_last_rd = 1'b0;
  bit          m_rsp_valid = 1'b0;
  bit          m_err = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_rdata = 32'd0;
  bit          last_acc = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_mem_re = 0;
  int          n_rsp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic drive(input logic v, input logic we, input logic [3:0] a,
                       input logic [31:0] d, input logic rr);
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
    #1;
  endtask

  // Compare the sampled cycle with the model, then advance the model to
  // what the coming clock edge commits.
  task automatic monitor();
    tb_req_t f;
    bit      exp_en, exp_re, nxt_rv;
    int      sz0;
    f = '0;
    exp_en = 1'b0;
    exp_re = 1'b0;
    sz0 = pend_q.size();
    if (sz0 > 0) begin
      f = pend_q[0];
      exp_en = f.we;
      exp_re = !f.we && !m_rsp_valid && !m_last_rd;
    end
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    chk("mem_re", 32'(mem_re), 32'(exp_re));
    chk("en_re_excl", 32'(mem_en & mem_re), 32'd0);
    chk("req_ready", 32'(req_ready), 32'(sz0 < 4));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    chk("rd_err", 32'(rd_err), 32'(m_err));
    if (exp_en || exp_re) begin
      chk("mem_addr", 32'(mem_addr), 32'(f.addr));
      if (exp_en) chk("mem_wdata", mem_wdata, f.wdata);
    end else begin
      chk("idle_addr", 32'(mem_addr), 32'd0);
      chk("idle_wdata", mem_wdata, 32'd0);
    end
    if (prev_hold) chk("rdata_hold", rsp_rdata, prev_rdata);
    if (m_rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) fail_now("rsp_unexpected");
      else chk("rsp_data", rsp_rdata, exp_q.pop_front());
      n_rsp++;
    end
    // Model advance for the coming edge.
    m_err = m_err || (m_last_rd && !mem_valid);
    if (m_last_rd) nxt_rv = 1'b1;
    else if (m_rsp_valid && rsp_ready) nxt_rv = 1'b0;
    else nxt_rv = m_rsp_valid;
    prev_hold = m_rsp_valid && !rsp_ready;
    prev_rdata = rsp_rdata;
    m_rsp_valid = nxt_rv;
    if (exp_en) begin
      ref_mem[f.addr] = f.wdata;
      void'(pend_q.pop_front());
    end
    if (exp_re) begin
      exp_q.push_back(ref_mem[f.addr]);
      void'(pend_q.pop_front());
      n_mem_re++;
    end
    m_last_rd = exp_re;
    last_acc = req_valid && (sz0 < 4);
    if (last_acc) pend_q.push_back({req_we, req_addr, req_wdata});
  endtask

  task automatic tick(input logic v, input logic we, input logic [3:0] a,
                      input logic [31:0] d, input logic rr);
    drive(v, we, a, d, rr);
    monitor();
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'd0, 32'd0, rr);
  endtask

  task automatic send(input logic we, input logic [3:0] a, input logic [31:0] d, input logic rr);
    int k;
    k = 0;
    do begin
      tick(1'b1, we, a, d, rr);
      k++;
    end while (!last_acc && k < 50);
    if (!last_acc) fail_now("send_timeout");
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((pend_q.size() != 0 || exp_q.size() != 0 || m_rsp_valid || m_last_rd) && k < 200) begin
      tick(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
      k++;
    end
    if (k >= 200) fail_now("drain_timeout");
  endtask

  // Asynchronous reset pulse: outputs must clear at once, not at an edge.
  task automatic do_reset();
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    pend_q.delete();
    exp_q.delete();
    m_last_rd = 1'b0;
    m_rsp_valid = 1'b0;
    m_err = 1'b0;
    prev_hold = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
  endtask

  typedef struct {
    logic        v, we;
    logic [3:0]  a;
    logic [31:0] d;
    logic        rr;
    logic        e_ready, e_en, e_re;
    logic [3:0]  e_addr;
    logic        e_rv;
    logic [31:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic we, input logic [3:0] a,
                              input logic [31:0] d, input logic rr, input logic e_en,
                              input logic e_re, input logic [3:0] e_addr,
                              input logic e_rv, input logic [31:0] e_rdata);
    vec_t r;
    r.v = v; r.we = we; r.a = a; r.d = d; r.rr = rr;
    r.e_ready = 1'b1; r.e_en = e_en; r.e_re = e_re; r.e_addr = e_addr;
    r.e_rv = e_rv; r.e_rdata = e_rdata;
    return r;
  endfunction

  vec_t tbl [15];

  initial begin
    int acc_cnt, re0, rsp0;
    // Write DEADBEEF@3 then read 3; then read/write(A5A5A5A5)/read on addr 3.
    tbl[0]  = mk(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
    tbl[1]  = mk(1'b1, 1'b0, 4'd3, 32'd0,        1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 32'd0);
    tbl[2]  = mk(1'b0, 1'b0, 4'd0, 32'd0,        1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 32'd0);
    tbl[3]  = mk(1'b0, 1'b0, 4'd0, 32'd0,        1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
    tbl[4]  = mk(1'b0, 1'b0, 4'd0, 32'd0,        1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 32'hDEADBEEF);
    tbl[5]  = mk(1'b0, 1'b0, 4'd0, 32'd0,        1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 32'hDEADBEEF);
    tbl[6]  = mk(1'b0, 1'b0, 4'd0, 32'd0,        1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
    tbl[7]  = mk(1'b1, 1'b0, 4'd3, 32'd0,        1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
    tbl[8]  = mk(1'b1, 1'b1, 4'd3, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 32'd0);
    tbl[9]  = mk(1'b1, 1'b0, 4'd3, 32'd0,        1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 32'd0);
    tbl[10] = mk(1'b0, 1'b0, 4'd0, 32'd0,        1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 32'hDEADBEEF);
    tbl[11] = mk(1'b0, 1'b0, 4'd0, 32'd0,        1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 32'd0);
    tbl[12] = mk(1'b0, 1'b0, 4'd0, 32'd0,        1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
    tbl[13] = mk(1'b0, 1'b0, 4'd0, 32'd0,        1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 32'hA5A5A5A5);
    tbl[14] = mk(1'b0, 1'b0, 4'd0, 32'd0,        1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);

    do_reset();

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rr);
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_en", i), 32'(mem_en), 32'(tbl[i].e_en));
      chk($sformatf("tbl%0d_re", i), 32'(mem_re), 32'(tbl[i].e_re));
      chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_rv", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_rdata", i), rsp_rdata, tbl[i].e_rdata);
      monitor();
      @(posedge clk);
    end

    // Five back-to-back reads with the consumer stalled.
    acc_cnt = 0;
    re0 = n_mem_re;
    rsp0 = n_rsp;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 4'(i), 32'd0, 1'b0);
      if (last_acc) acc_cnt++;
    end
    chk("burst_accepts", 32'(acc_cnt), 32'd5);
    drive(1'b1, 1'b0, 4'd9, 32'd0, 1'b0);
    chk("burst_full_ready", 32'(req_ready), 32'd0);
    monitor();
    @(posedge clk);
    idle(4, 1'b0);
    chk("burst_one_re", 32'(n_mem_re - re0), 32'd1);
    drain();
    chk("burst_rsp_cnt", 32'(n_rsp - rsp0), 32'd5);
    chk("burst_re_cnt", 32'(n_mem_re - re0), 32'd5);

    // Fill all 16 words, read them back; pointers wrap several times.
    rsp0 = n_rsp;
    for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 32'(i + 1), 1'b1);
    for (int i = 0; i < 16; i++) send(1'b0, 4'(i), 32'd0, 1'b1);
    drain();
    chk("sweep_rsp_cnt", 32'(n_rsp - rsp0), 32'd16);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom, 1'($urandom_range(0, 3) != 0));
    end
    drain();

    // Reset with a held response and three requests queued.
    send(1'b0, 4'd5, 32'd0, 1'b0);
    send(1'b0, 4'd6, 32'd0, 1'b0);
    send(1'b1, 4'd7, 32'h77777777, 1'b0);
    send(1'b0, 4'd8, 32'd0, 1'b0);
    chk("pre_rst_queued", 32'(pend_q.size()), 32'd3);
    do_reset();
    idle(6, 1'b1);
    send(1'b0, 4'd7, 32'd0, 1'b1);
    drain();

    // Missing mem_valid on a read return sets the sticky error.
    kill_valid = 1'b1;
    send(1'b0, 4'd3, 32'd0, 1'b1);
    drain();
    kill_valid = 1'b0;
    chk("rd_err_set", 32'(rd_err), 32'd1);
    idle(4, 1'b1);
    send(1'b1, 4'd2, 32'h12345678, 1'b1);
    send(1'b0, 4'd2, 32'd0, 1'b1);
    drain();
    chk("rd_err_sticky", 32'(rd_err), 32'd1);
    do_reset();
    idle(2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
